// File: rtl/counter_pkg.sv
// Shared direction/mode constants and the clamp helper for the modulo step counter family.
package counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Limits a value to the counter range 0..modulus-1.
    function automatic int unsigned clamp_to_mod(input int unsigned v, input int unsigned modulus);
        return (v > modulus - 1) ? modulus - 1 : v;
    endfunction

endpackage

// File: rtl/mod_step_next.sv
// Combinational next-count and range-event calculation for mod_step_counter.
module mod_step_next
    import counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD   = 10
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] s,
    input  logic             up,
    input  logic             sat,
    output logic [WIDTH-1:0] nxt,
    output logic             evt
);

    // Two guard bits keep count+s and count-s exact for any legal MOD.
    localparam logic signed [WIDTH+1:0] MOD_X = (WIDTH+2)'(MOD);
    localparam logic signed [WIDTH+1:0] MAX_X = (WIDTH+2)'(MOD - 1);

    logic signed [WIDTH+1:0] cnt_x;
    logic signed [WIDTH+1:0] s_x;
    logic signed [WIDTH+1:0] r;

    always_comb begin
        cnt_x = $signed({2'b00, count});
        s_x   = $signed({2'b00, s});
        r     = cnt_x;
        evt   = 1'b0;
        if (up == DIR_UP) begin
            r = cnt_x + s_x;
            if (r > MAX_X) begin
                evt = 1'b1;
                r   = (sat == MODE_WRAP) ? r - MOD_X : MAX_X;
            end
        end
        if (up == DIR_DOWN) begin
            r = cnt_x - s_x;
            if (r[WIDTH+1]) begin
                evt = 1'b1;
                r   = (sat == MODE_WRAP) ? r + MOD_X : '0;
            end
        end
        nxt = r[WIDTH-1:0];
    end

endmodule

// File: rtl/mod_step_counter.sv
// Modulo counter with variable step, up/down, wrap/saturate and a chainable range-event pulse.
// Optional sticky event flag ovf_sticky enabled by defining COUNTER_STICKY_OVF_EN.
module mod_step_counter
    import counter_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int MOD    = 10,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cnt_en,
    input  logic              up,
    input  logic              sat,
    input  logic [STEP_W-1:0] step,
    input  logic              load,
    input  logic              clear,
    input  logic [WIDTH-1:0]  data_in,
    output logic [WIDTH-1:0]  count,
    output logic              at_max,
    output logic              at_zero,
    output logic              evt
`ifdef COUNTER_STICKY_OVF_EN
    ,
    output logic              ovf_sticky
`endif
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] s_eff;
    logic [WIDTH-1:0] ld_val;
    logic [WIDTH-1:0] nxt_val;
    logic             nxt_evt;
    logic [WIDTH-1:0] cnt_p0;
    logic             evt_p0;

    assign s_eff  = WIDTH'(clamp_to_mod(32'(step), MOD));
    assign ld_val = WIDTH'(clamp_to_mod(32'(data_in), MOD));

    mod_step_next #(
        .WIDTH (WIDTH),
        .MOD   (MOD)
    ) u_next (
        .count (cnt_p0),
        .s     (s_eff),
        .up    (up),
        .sat   (sat),
        .nxt   (nxt_val),
        .evt   (nxt_evt)
    );

    // Stage p0: count and event registers, priority clear > load > cnt_en > hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_p0 <= '0;
            evt_p0 <= 1'b0;
        end else if (clear) begin
            cnt_p0 <= '0;
            evt_p0 <= 1'b0;
        end else if (load) begin
            cnt_p0 <= ld_val;
            evt_p0 <= 1'b0;
        end else if (cnt_en) begin
            cnt_p0 <= nxt_val;
            evt_p0 <= nxt_evt;
        end else begin
            evt_p0 <= 1'b0;
        end
    end

`ifdef COUNTER_STICKY_OVF_EN
    logic stk_p0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stk_p0 <= 1'b0;
        end else if (clear) begin
            stk_p0 <= 1'b0;
        end else if (!load && cnt_en && nxt_evt) begin
            stk_p0 <= 1'b1;
        end
    end

    assign ovf_sticky = stk_p0;
`endif

    assign count   = cnt_p0;
    assign evt     = evt_p0;
    assign at_max  = (cnt_p0 == MAX_V);
    assign at_zero = (cnt_p0 == '0);

endmodule

// File: tb/tb_mod_step_counter.sv
// Scoreboard bench for mod_step_counter: directed scenarios plus randomized traffic vs. an integer model.
module tb_mod_step_counter;

    localparam int WIDTH  = 4;
    localparam int MOD    = 10;
    localparam int STEP_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cnt_en = 1'b0;
    logic              up = 1'b0;
    logic              sat = 1'b0;
    logic [STEP_W-1:0] step = '0;
    logic              load = 1'b0;
    logic              clear = 1'b0;
    logic [WIDTH-1:0]  data_in = '0;
    logic [WIDTH-1:0]  count;
    logic              at_max;
    logic              at_zero;
    logic              evt;
`ifdef COUNTER_STICKY_OVF_EN
    logic              ovf_sticky;
`endif

    typedef struct {
        int cnt;
        int evt;
        int stk;
        int id;
    } exp_t;

    exp_t sb[$];
    int   m_cnt = 0;
    int   m_evt = 0;
    int   m_stk = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc_id = 0;

    mod_step_counter #(
        .WIDTH  (WIDTH),
        .MOD    (MOD),
        .STEP_W (STEP_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cnt_en  (cnt_en),
        .up      (up),
        .sat     (sat),
        .step    (step),
        .load    (load),
        .clear   (clear),
        .data_in (data_in),
        .count   (count),
        .at_max  (at_max),
        .at_zero (at_zero),
        .evt     (evt)
`ifdef COUNTER_STICKY_OVF_EN
        ,
        .ovf_sticky (ovf_sticky)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference behaviour: plain integer arithmetic on the counter range.
    task automatic model_step(input bit c, input bit l, input bit e, input bit u, input bit sa,
                              input int stp, input int din);
        int s;
        int r;
        if (c) begin
            m_cnt = 0;
            m_evt = 0;
            m_stk = 0;
        end else if (l) begin
            m_cnt = (din > MOD - 1) ? MOD - 1 : din;
            m_evt = 0;
        end else if (e) begin
            s = (stp > MOD - 1) ? MOD - 1 : stp;
            r = u ? m_cnt + s : m_cnt - s;
            m_evt = 0;
            if (r > MOD - 1) begin
                m_evt = 1;
                m_cnt = sa ? MOD - 1 : r - MOD;
            end else if (r < 0) begin
                m_evt = 1;
                m_cnt = sa ? 0 : r + MOD;
            end else begin
                m_cnt = r;
            end
            if (m_evt == 1) m_stk = 1;
        end else begin
            m_evt = 0;
        end
    endtask

    task automatic cyc(input bit c, input bit l, input bit e, input bit u, input bit sa,
                       input int stp, input int din);
        exp_t x;
        @(posedge clk);
        #2;
        clear   = c;
        load    = l;
        cnt_en  = e;
        up      = u;
        sat     = sa;
        step    = STEP_W'(stp);
        data_in = WIDTH'(din);
        model_step(c, l, e, u, sa, stp, din);
        cyc_id++;
        x.cnt = m_cnt;
        x.evt = m_evt;
        x.stk = m_stk;
        x.id  = cyc_id;
        sb.push_back(x);
    endtask

    // Monitor: the counter presents a fresh result after every edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk($sformatf("count@%0d", x.id), int'(count), x.cnt);
                chk($sformatf("evt@%0d", x.id), int'(evt), x.evt);
                chk($sformatf("at_max@%0d", x.id), int'(at_max), int'(x.cnt == MOD - 1));
                chk($sformatf("at_zero@%0d", x.id), int'(at_zero), int'(x.cnt == 0));
`ifdef COUNTER_STICKY_OVF_EN
                chk($sformatf("ovf_sticky@%0d", x.id), int'(ovf_sticky), x.stk);
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #22;
        rst = 1'b0;
        #1;
        chk("reset_count", int'(count), 0);
        chk("reset_at_zero", int'(at_zero), 1);
        chk("reset_at_max", int'(at_max), 0);
        chk("reset_evt", int'(evt), 0);
`ifdef COUNTER_STICKY_OVF_EN
        chk("reset_sticky", int'(ovf_sticky), 0);
`endif
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // Load 7, wrap up through MOD-1
        cyc(0, 1, 0, 1, 0, 0, 7);
        repeat (4) cyc(0, 0, 1, 1, 0, 1, 0);

        // Step 3 wrap up then down
        cyc(0, 1, 0, 0, 0, 0, 8);
        cyc(0, 0, 1, 1, 0, 3, 0);
        cyc(0, 0, 1, 0, 0, 3, 0);

        // Saturate at zero, then zero step
        cyc(0, 1, 0, 0, 0, 0, 2);
        repeat (3) cyc(0, 0, 1, 0, 1, 3, 0);
        cyc(0, 0, 1, 0, 1, 0, 0);

        // Saturate at max, oversized step clamps to MOD-1
        cyc(0, 1, 0, 0, 0, 0, 5);
        cyc(0, 0, 1, 1, 1, 15, 0);
        cyc(0, 0, 1, 1, 1, 2, 0);
        cyc(0, 0, 1, 0, 0, 15, 0);

        // Load clamp and priorities
        cyc(0, 1, 0, 0, 0, 0, 12);
        cyc(1, 1, 0, 0, 0, 0, 5);
        cyc(0, 1, 1, 1, 0, 1, 4);

        // Sticky flag lifetime
        cyc(0, 1, 0, 0, 0, 0, 9);
        cyc(0, 0, 1, 1, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 0, 3);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 1, 0, 9, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset mid-count at 6
        cyc(0, 1, 0, 0, 0, 0, 5);
        cyc(0, 0, 1, 1, 0, 1, 0);
        @(posedge clk);
        #2;
        clear  = 1'b0;
        load   = 1'b0;
        cnt_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_count", int'(count), 0);
        chk("async_rst_at_zero", int'(at_zero), 1);
        chk("async_rst_evt", int'(evt), 0);
        m_cnt = 0;
        m_evt = 0;
        m_stk = 0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        cyc(0, 0, 1, 1, 0, 1, 0);
        cyc(0, 0, 1, 1, 0, 1, 0);

        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        #3;
        chk("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
